// File: rtl/tcp_tx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tcp_tx_pkt_buffer
// Brief    : Store-and-forward TX packet buffer between the TCP engine and MAC;
//            releases whole packets only, drops packets that do not fit.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_tx_pkt_buffer #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W / 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                net_clk,
    input  logic                net_aresetn,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [KEEP_W-1:0]   s_axis_tkeep,
    input  logic                s_axis_tdest,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [KEEP_W-1:0]   m_axis_tkeep,
    output logic                m_axis_tdest,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         tx_pkt_cnt,
    output logic [31:0]         drop_pkt_cnt,
    output logic [ADDR_W:0]     occupancy
);

    localparam int              c_ENTRY_W  = DATA_W + KEEP_W + 2;
    localparam logic [ADDR_W:0] c_PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_FULL_LVL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_WRITE = 1'b0,
        ST_DROP  = 1'b1
    } wr_state_t;

    wr_state_t              r_state;
    wr_state_t              w_state_nxt;

    logic [ADDR_W:0]        r_wr_ptr;
    logic [ADDR_W:0]        r_commit_ptr;
    logic [ADDR_W:0]        r_rd_ptr;
    logic [ADDR_W:0]        r_fetch_ptr;
    logic [ADDR_W:0]        w_wr_ptr_nxt;
    logic [ADDR_W:0]        w_commit_ptr_nxt;
    logic [ADDR_W:0]        w_used;
    logic                   w_full;
    logic                   w_wr_en;
    logic                   w_drop;

    logic [c_ENTRY_W-1:0]   r_mem [DEPTH];
    logic [c_ENTRY_W-1:0]   w_wr_data;
    logic [c_ENTRY_W-1:0]   r_ram_q;
    logic                   r_ram_vld;
    logic [c_ENTRY_W-1:0]   r_out_q;
    logic                   r_out_vld;
    logic                   w_avail;
    logic                   w_out_fire;
    logic                   w_ram_move;
    logic                   w_rd_en;

    logic [31:0]            r_tx_pkt_cnt;
    logic [31:0]            r_drop_pkt_cnt;

    assign s_axis_tready = net_aresetn;
    assign w_wr_data     = {s_axis_tdata, s_axis_tkeep, s_axis_tdest, s_axis_tlast};

    // rd_ptr only moves on consumption, so flits parked in the read pipeline
    // still occupy their RAM slots and count toward fullness.
    assign w_used = r_wr_ptr - r_rd_ptr;
    assign w_full = (w_used == c_FULL_LVL);

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_en          = 1'b0;
        w_drop           = 1'b0;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        case (r_state)
            ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (!w_full) begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
                        if (s_axis_tlast) begin
                            w_commit_ptr_nxt = r_wr_ptr + c_PTR_ONE;
                        end
                    end else begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_drop       = 1'b1;
                        if (!s_axis_tlast) begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default: w_state_nxt = ST_WRITE;
        endcase
    end

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            r_state        <= ST_WRITE;
            r_wr_ptr       <= '0;
            r_commit_ptr   <= '0;
            r_drop_pkt_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
            if (w_drop) begin
                r_drop_pkt_cnt <= r_drop_pkt_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge net_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wr_data;
        end
    end

    // Two-stage read pipeline: RAM output register feeding the FWFT output
    // register; each stage refills in the same cycle it drains.
    assign w_avail    = (r_fetch_ptr != r_commit_ptr);
    assign w_out_fire = r_out_vld & m_axis_tready;
    assign w_ram_move = r_ram_vld & (~r_out_vld | w_out_fire);
    assign w_rd_en    = w_avail & (~r_ram_vld | w_ram_move);

    always_ff @(posedge net_clk) begin
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_fetch_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            r_fetch_ptr  <= '0;
            r_rd_ptr     <= '0;
            r_ram_vld    <= 1'b0;
            r_out_vld    <= 1'b0;
            r_out_q      <= '0;
            r_tx_pkt_cnt <= '0;
        end else begin
            if (w_rd_en) begin
                r_fetch_ptr <= r_fetch_ptr + c_PTR_ONE;
                r_ram_vld   <= 1'b1;
            end else if (w_ram_move) begin
                r_ram_vld <= 1'b0;
            end

            if (w_ram_move) begin
                r_out_q   <= r_ram_q;
                r_out_vld <= 1'b1;
            end else if (w_out_fire) begin
                r_out_vld <= 1'b0;
            end

            if (w_out_fire) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                if (r_out_q[0]) begin
                    r_tx_pkt_cnt <= r_tx_pkt_cnt + 32'd1;
                end
            end
        end
    end

    assign m_axis_tdata  = r_out_q[c_ENTRY_W-1 -: DATA_W];
    assign m_axis_tkeep  = r_out_q[KEEP_W+1 -: KEEP_W];
    assign m_axis_tdest  = r_out_q[1];
    assign m_axis_tlast  = r_out_q[0];
    assign m_axis_tvalid = r_out_vld;
    assign tx_pkt_cnt    = r_tx_pkt_cnt;
    assign drop_pkt_cnt  = r_drop_pkt_cnt;
    assign occupancy     = w_used;

endmodule
`default_nettype wire
